// File: rtl/srt2_div_param.sv
// Parametrised radix-2 SRT divider (unsigned/signed), one quotient digit per clock.
// Optional macro SRT2_EARLY_EXIT_EN: bypass iteration when |dividend| < |divisor|.
module srt2_div_param #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             divisionBy0,
    output logic             overflow
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int KW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, NORM, ITER, CORRECT, FINISH} state_t;

    state_t           state;
    logic [WIDTH-1:0] xa, da, dn;
    logic [WIDTH:0]   p;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] qp, qm, q;
    logic [KW-1:0]    k;
    logic [CW-1:0]    cnt;
    logic             q_neg, r_neg;

    // Position of the highest set bit wins; input is never zero when used.
    function automatic logic [KW-1:0] lzc(input logic [WIDTH-1:0] v);
        logic [KW-1:0] n;
        n = '0;
        for (int i = 0; i < WIDTH; i++)
            if (v[i]) n = KW'(WIDTH - 1 - i);
        return n;
    endfunction

    logic             x_neg, d_neg;
    logic [WIDTH-1:0] x_abs, d_abs;
    logic [KW-1:0]    k_n;
    logic [2*WIDTH:0] ps_norm;
    logic [WIDTH:0]   t, d_ext, p_next;
    logic             dig_pos, dig_neg;
    logic [WIDTH-1:0] q_diff, r_mag;

    always_comb begin
        x_neg   = signed_mode & dividend[WIDTH-1];
        d_neg   = signed_mode & divisor[WIDTH-1];
        x_abs   = x_neg ? -dividend : dividend;
        d_abs   = d_neg ? -divisor : divisor;
        k_n     = lzc(da);
        ps_norm = {{(WIDTH+1){1'b0}}, xa} << k_n;
        d_ext   = {1'b0, dn};
        t       = {p[WIDTH-1:0], s[WIDTH-1]};
        dig_pos = 1'b0;
        dig_neg = 1'b0;
        p_next  = t;
        // Redundant digit selection from the top three partial-remainder bits.
        case (p[WIDTH:WIDTH-2])
            3'b001, 3'b010, 3'b011: begin
                dig_pos = 1'b1;
                p_next  = t - d_ext;
            end
            3'b100, 3'b101, 3'b110: begin
                dig_neg = 1'b1;
                p_next  = t + d_ext;
            end
            default: p_next = t;
        endcase
        q_diff = qp - qm;
        r_mag  = p[WIDTH-1:0] >> k;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            xa          <= '0;
            da          <= '0;
            dn          <= '0;
            p           <= '0;
            s           <= '0;
            qp          <= '0;
            qm          <= '0;
            q           <= '0;
            k           <= '0;
            cnt         <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            divisionBy0 <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= '1;
                            divisionBy0 <= 1'b1;
                            overflow    <= 1'b0;
                            done        <= 1'b1;
                        end else if (signed_mode && dividend == MIN && divisor == '1) begin
                            quotient    <= MIN;
                            remainder   <= '0;
                            divisionBy0 <= 1'b0;
                            overflow    <= 1'b1;
                            done        <= 1'b1;
                        end else begin
                            xa          <= x_abs;
                            da          <= d_abs;
                            q_neg       <= x_neg ^ d_neg;
                            r_neg       <= x_neg;
                            divisionBy0 <= 1'b0;
                            overflow    <= 1'b0;
                            busy        <= 1'b1;
                            state       <= NORM;
                        end
                    end
                end
                NORM: begin
                    qp  <= '0;
                    qm  <= '0;
                    cnt <= '0;
`ifdef SRT2_EARLY_EXIT_EN
                    if (xa < da) begin
                        p     <= {1'b0, xa};
                        k     <= '0;
                        q     <= '0;
                        state <= FINISH;
                    end else begin
                        k     <= k_n;
                        dn    <= da << k_n;
                        p     <= ps_norm[2*WIDTH:WIDTH];
                        s     <= ps_norm[WIDTH-1:0];
                        state <= ITER;
                    end
`else
                    k     <= k_n;
                    dn    <= da << k_n;
                    p     <= ps_norm[2*WIDTH:WIDTH];
                    s     <= ps_norm[WIDTH-1:0];
                    state <= ITER;
`endif
                end
                ITER: begin
                    p   <= p_next;
                    s   <= {s[WIDTH-2:0], 1'b0};
                    qp  <= {qp[WIDTH-2:0], dig_pos};
                    qm  <= {qm[WIDTH-2:0], dig_neg};
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1))
                        state <= CORRECT;
                end
                CORRECT: begin
                    // Negative final remainder: step back one divisor.
                    if (p[WIDTH]) begin
                        p <= p + d_ext;
                        q <= q_diff - WIDTH'(1);
                    end else begin
                        q <= q_diff;
                    end
                    state <= FINISH;
                end
                FINISH: begin
                    quotient  <= q_neg ? -q : q;
                    remainder <= r_neg ? -r_mag : r_mag;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_srt2_div_param.sv
// Directed vector bench for srt2_div_param at WIDTH=8.
module tb_srt2_div_param;
    localparam int W  = 8;
    localparam int LN = W + 3;
`ifdef SRT2_EARLY_EXIT_EN
    localparam int LE = 2;
`else
    localparam int LE = W + 3;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         signed_mode = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic [W-1:0] quotient, remainder;
    logic         busy, done, divisionBy0, overflow;

    int checks = 0;
    int failures = 0;

    srt2_div_param #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
        .dividend(dividend), .divisor(divisor), .quotient(quotient),
        .remainder(remainder), .busy(busy), .done(done),
        .divisionBy0(divisionBy0), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         sm;
        logic [W-1:0] a, b, q, r;
        logic         dz, ov;
        int           lat;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Launch one operation; lat = edges after the accepting edge until done is seen.
    task automatic run_op(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output logic busy_bad);
        @(negedge clk);
        start = 1'b1; signed_mode = sm; dividend = a; divisor = b;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        busy_bad = 1'b0;
        while (!done && lat < 40) begin
            if (!busy) busy_bad = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic set_vec(input int i, input logic sm, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] q, input logic [W-1:0] r,
                           input logic dz, input logic ov, input int lat);
        vecs[i].sm = sm; vecs[i].a = a; vecs[i].b = b; vecs[i].q = q; vecs[i].r = r;
        vecs[i].dz = dz; vecs[i].ov = ov; vecs[i].lat = lat;
    endtask

    initial begin
        int   lat;
        logic bb;
        int   done_seen;

        set_vec(0,  0, 8'd200, 8'd10,  8'd20,  8'd0,   0, 0, LN);
        set_vec(1,  0, 8'd57,  8'd5,   8'd11,  8'd2,   0, 0, LN);
        set_vec(2,  0, 8'd255, 8'd255, 8'd1,   8'd0,   0, 0, LN);
        set_vec(3,  0, 8'd1,   8'd1,   8'd1,   8'd0,   0, 0, LN);
        set_vec(4,  0, 8'd255, 8'd1,   8'd255, 8'd0,   0, 0, LN);
        set_vec(5,  0, 8'd7,   8'd200, 8'd0,   8'd7,   0, 0, LE);
        set_vec(6,  1, 8'h9C,  8'h07,  8'hF2,  8'hFE,  0, 0, LN);
        set_vec(7,  1, 8'h64,  8'hF9,  8'hF2,  8'h02,  0, 0, LN);
        set_vec(8,  1, 8'h80,  8'hFF,  8'h80,  8'h00,  0, 1, 0);
        set_vec(9,  0, 8'd100, 8'd0,   8'hFF,  8'hFF,  1, 0, 0);
        set_vec(10, 1, 8'd100, 8'd0,   8'hFF,  8'hFF,  1, 0, 0);
        set_vec(11, 0, 8'h80,  8'h80,  8'd1,   8'd0,   0, 0, LN);
        set_vec(12, 1, 8'h80,  8'h01,  8'h80,  8'h00,  0, 0, LN);
        set_vec(13, 1, 8'hF9,  8'h02,  8'hFD,  8'hFF,  0, 0, LN);
        set_vec(14, 1, 8'hFF,  8'hFF,  8'h01,  8'h00,  0, 0, LN);
        set_vec(15, 1, 8'h7F,  8'h80,  8'h00,  8'h7F,  0, 0, LE);
        set_vec(16, 0, 8'h80,  8'hFF,  8'h00,  8'h80,  0, 0, LE);
        set_vec(17, 0, 8'hFF,  8'h80,  8'h01,  8'h7F,  0, 0, LN);

        #12;
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_div0", divisionBy0, 0);
        chk("rst_ovf", overflow, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            run_op(vecs[i].sm, vecs[i].a, vecs[i].b, lat, bb);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            chk($sformatf("v%0d_busy_during", i), bb, 0);
            chk($sformatf("v%0d_busy_at_done", i), busy, 0);
            chk($sformatf("v%0d_quotient", i), quotient, vecs[i].q);
            chk($sformatf("v%0d_remainder", i), remainder, vecs[i].r);
            chk($sformatf("v%0d_div0", i), divisionBy0, vecs[i].dz);
            chk($sformatf("v%0d_ovf", i), overflow, vecs[i].ov);
            @(posedge clk); #1;
            chk($sformatf("v%0d_done_pulse", i), done, 0);
            chk($sformatf("v%0d_div0_held", i), divisionBy0, vecs[i].dz);
            chk($sformatf("v%0d_quot_held", i), quotient, vecs[i].q);
        end

        // Re-pulsed start at edge 5 of a running operation must be ignored.
        @(negedge clk);
        start = 1'b1; signed_mode = 1'b0; dividend = 8'd57; divisor = 8'd5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        start = 1'b1; dividend = 8'd200; divisor = 8'd10;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 5;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("ignore_latency", lat, LN);
        chk("ignore_quotient", quotient, 8'd11);
        chk("ignore_remainder", remainder, 8'd2);
        @(posedge clk); #1;
        chk("ignore_no_second_done", done, 0);
        chk("ignore_idle", busy, 0);

        // Reset at edge 6 of an operation aborts it with no done pulse.
        @(negedge clk);
        start = 1'b1; dividend = 8'd200; divisor = 8'd10;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_quotient", quotient, 0);
        chk("abort_remainder", remainder, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done) done_seen++;
        end
        chk("abort_no_done", done_seen, 0);
        chk("abort_busy_after", busy, 0);
        run_op(1'b0, 8'd57, 8'd5, lat, bb);
        chk("post_abort_latency", lat, LN);
        chk("post_abort_quotient", quotient, 8'd11);
        chk("post_abort_remainder", remainder, 8'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
